// File: rtl/obstacle_spawner_pkg.sv
// Shared definitions for the obstacle spawner: FSM encoding, lane geometry,
// screen height default and obstacle type encoding.
package obstacle_spawner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_READY = 2'd2
    } state_e;

    localparam int unsigned NUM_LANES     = 4;
    localparam int unsigned LANE_W        = $clog2(NUM_LANES);
    localparam int unsigned Y_W           = 10;
    localparam int unsigned SCREEN_H_DFLT = 480;

    typedef enum logic {
        OBJ_CIRCLE = 1'b0,   // collect
        OBJ_SQUARE = 1'b1    // avoid
    } obj_type_e;

endpackage

// File: rtl/obstacle_spawner_slot.sv
// One obstacle slot: holds valid/lane/type/y, moves down on a tick and
// frees itself when it falls past the bottom of the screen.
module obstacle_slot
    import obstacle_spawner_pkg::*;
#(
    parameter int unsigned SPEED    = 2,
    parameter int unsigned SCREEN_H = SCREEN_H_DFLT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear_i,
    input  logic              move_i,
    input  logic              load_i,
    input  logic [LANE_W-1:0] lane_i,
    input  logic              type_i,
    output logic              valid_o,
    output logic [LANE_W-1:0] lane_o,
    output logic              type_o,
    output logic [Y_W-1:0]    y_o,
    output logic              exit_o
);

    logic              valid_q, valid_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              type_q, type_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [Y_W:0]      y_sum;

    // One extra bit so the compare against SCREEN_H never sees a wrapped y.
    assign y_sum  = {1'b0, y_q} + (Y_W+1)'(SPEED);
    assign exit_o = move_i & valid_q & (32'(y_sum) >= SCREEN_H);

    // Next-state: clear wins, then load (only ever into a free slot), then move/exit.
    always_comb begin
        valid_d = valid_q;
        lane_d  = lane_q;
        type_d  = type_q;
        y_d     = y_q;
        if (clear_i) begin
            valid_d = 1'b0;
            lane_d  = '0;
            type_d  = OBJ_CIRCLE;
            y_d     = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            lane_d  = lane_i;
            type_d  = type_i;
            y_d     = '0;
        end else if (move_i && valid_q) begin
            if (exit_o) begin
                valid_d = 1'b0;
                lane_d  = '0;
                type_d  = OBJ_CIRCLE;
                y_d     = '0;
            end else begin
                y_d = y_sum[Y_W-1:0];
            end
        end
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            lane_q  <= '0;
            type_q  <= OBJ_CIRCLE;
            y_q     <= '0;
        end else begin
            valid_q <= valid_d;
            lane_q  <= lane_d;
            type_q  <= type_d;
            y_q     <= y_d;
        end
    end

    assign valid_o = valid_q;
    assign lane_o  = lane_q;
    assign type_o  = type_q;
    assign y_o     = y_q;

endmodule

// File: rtl/obstacle_spawner.sv
// Obstacle spawner: paces spawns with a frame-tick gap counter and keeps
// NSLOT falling obstacles, reporting spawn/exit/overflow as one-cycle pulses.
module obstacle_spawner
    import obstacle_spawner_pkg::*;
#(
    parameter int unsigned NSLOT     = 4,
    parameter int unsigned SPEED     = 2,
    parameter int unsigned SPAWN_GAP = 60,
    parameter int unsigned SCREEN_H  = SCREEN_H_DFLT
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    frame_tick,
    input  logic [4:0]              rand_data,
    input  logic                    enable,
    input  logic                    clear,
    output logic [NSLOT-1:0]        obj_valid,
    output logic [LANE_W*NSLOT-1:0] obj_lane,
    output logic [NSLOT-1:0]        obj_type,
    output logic [Y_W*NSLOT-1:0]    obj_y,
    output logic                    spawn_pulse,
    output logic                    exit_pulse,
    output logic                    exit_type,
    output logic                    overflow
);

    localparam int unsigned GAP_W = $clog2(SPAWN_GAP + 2);

    state_e             state_q, state_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               spawn_d, ovf_d, exit_type_d;
    logic               move;
    logic               free_any;
    logic [NSLOT-1:0]   free_onehot, load_vec, exit_vec;

    assign move = enable & frame_tick & ~clear;

    // Lowest-index free slot, judged on pre-tick valid so a slot leaving
    // the screen this tick cannot be refilled in the same tick.
    always_comb begin
        free_onehot = '0;
        free_any    = 1'b0;
        for (int i = 0; i < int'(NSLOT); i++) begin
            if (!obj_valid[i] && !free_any) begin
                free_onehot[i] = 1'b1;
                free_any       = 1'b1;
            end
        end
    end

    // FSM next-state and spawn decision. READY is entered after SPAWN_GAP-1
    // ticks so the SPAWN_GAP-th tick is the first one allowed to spawn,
    // keeping consecutive spawns at least SPAWN_GAP ticks apart.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        spawn_d   = 1'b0;
        ovf_d     = 1'b0;
        load_vec  = '0;
        if (clear) begin
            state_d   = enable ? ST_GAP : ST_IDLE;
            gap_cnt_d = '0;
        end else if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_GAP;
                ST_GAP: begin
                    if (frame_tick) begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                        if (32'(gap_cnt_q) + 32'd2 >= SPAWN_GAP)
                            state_d = ST_READY;
                    end
                end
                ST_READY: begin
                    if (frame_tick && rand_data[4:3] != 2'b00) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                        if (free_any) begin
                            load_vec = free_onehot;
                            spawn_d  = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // exit_type reports the lowest-index slot that exited; descending scan
    // lets the lowest index write last.
    always_comb begin
        exit_type_d = 1'b0;
        for (int i = int'(NSLOT) - 1; i >= 0; i--) begin
            if (exit_vec[i]) exit_type_d = obj_type[i];
        end
    end

    // FSM state, gap counter and registered event pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            gap_cnt_q   <= '0;
            spawn_pulse <= 1'b0;
            overflow    <= 1'b0;
            exit_pulse  <= 1'b0;
            exit_type   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            spawn_pulse <= spawn_d;
            overflow    <= ovf_d;
            exit_pulse  <= |exit_vec;
            exit_type   <= exit_type_d;
        end
    end

    for (genvar g = 0; g < int'(NSLOT); g++) begin : g_slot
        obstacle_slot #(
            .SPEED    (SPEED),
            .SCREEN_H (SCREEN_H)
        ) u_slot (
            .clk     (clk),
            .rstn    (rstn),
            .clear_i (clear),
            .move_i  (move),
            .load_i  (load_vec[g]),
            .lane_i  (rand_data[LANE_W-1:0]),
            .type_i  (rand_data[2]),
            .valid_o (obj_valid[g]),
            .lane_o  (obj_lane[LANE_W*g +: LANE_W]),
            .type_o  (obj_type[g]),
            .y_o     (obj_y[Y_W*g +: Y_W]),
            .exit_o  (exit_vec[g])
        );
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Scoreboard bench for obstacle_spawner: a slot-list reference model pushes
// expected spawn/exit/overflow events; a monitor pops them on DUT pulses.
module tb_obstacle_spawner;

    localparam int NSLOT     = 4;
    localparam int SPEED     = 2;
    localparam int SPAWN_GAP = 60;
    localparam int SCREEN_H  = 480;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 frame_tick = 1'b0;
    logic [4:0]           rand_data = '0;
    logic                 enable = 1'b0;
    logic                 clear = 1'b0;
    logic [NSLOT-1:0]     obj_valid;
    logic [2*NSLOT-1:0]   obj_lane;
    logic [NSLOT-1:0]     obj_type;
    logic [10*NSLOT-1:0]  obj_y;
    logic                 spawn_pulse, exit_pulse, exit_type, overflow;

    obstacle_spawner #(
        .NSLOT(NSLOT), .SPEED(SPEED), .SPAWN_GAP(SPAWN_GAP), .SCREEN_H(SCREEN_H)
    ) dut (
        .clk(clk), .rstn(rstn), .frame_tick(frame_tick), .rand_data(rand_data),
        .enable(enable), .clear(clear), .obj_valid(obj_valid), .obj_lane(obj_lane),
        .obj_type(obj_type), .obj_y(obj_y), .spawn_pulse(spawn_pulse),
        .exit_pulse(exit_pulse), .exit_type(exit_type), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct { bit sp; bit ov; bit ex; bit et; } ev_t;
    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    // reference model: plain list of falling objects plus ticks since last attempt
    bit mv[NSLOT];
    int ml[NSLOT], mt[NSLOT], my[NSLOT];
    int ticks_since;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NSLOT; i++) begin
            mv[i] = 0; ml[i] = 0; mt[i] = 0; my[i] = 0;
        end
        ticks_since = 0;
    endfunction

    function automatic void model_tick(input logic [4:0] rd);
        bit pv[NSLOT];
        bit ex, et, sp, ov;
        int f;
        ex = 0; et = 0; sp = 0; ov = 0; f = -1;
        for (int i = 0; i < NSLOT; i++) pv[i] = mv[i];
        for (int i = 0; i < NSLOT; i++) begin
            if (mv[i]) begin
                my[i] += SPEED;
                if (my[i] >= SCREEN_H) begin
                    mv[i] = 0;
                    if (!ex) et = bit'(mt[i]);
                    ex = 1;
                end
            end
        end
        ticks_since++;
        if (ticks_since >= SPAWN_GAP && rd[4:3] != 2'b00) begin
            ticks_since = 0;
            for (int i = 0; i < NSLOT; i++) if (!pv[i] && f < 0) f = i;
            if (f >= 0) begin
                mv[f] = 1; ml[f] = int'(rd[1:0]); mt[f] = int'(rd[2]); my[f] = 0;
                sp = 1;
            end else begin
                ov = 1;
            end
        end
        if (sp || ov || ex) exp_q.push_back('{sp: sp, ov: ov, ex: ex, et: et});
    endfunction

    // compare occupied slots field-by-field; free slots compare only valid
    task automatic check_state(input string name);
        logic [63:0] a, e;
        a = '0; e = '0;
        for (int i = 0; i < NSLOT; i++) begin
            a[14*i +: 14] = {obj_valid[i], mv[i] ? {obj_lane[2*i +: 2], obj_type[i], obj_y[10*i +: 10]} : 13'd0};
            e[14*i +: 14] = {mv[i], mv[i] ? {2'(ml[i]), 1'(mt[i]), 10'(my[i])} : 13'd0};
        end
        chk(name, a, e);
    endtask

    task automatic do_tick(input logic [4:0] rd, input int gap);
        @(negedge clk);
        frame_tick = 1'b1;
        rand_data  = rd;
        model_tick(rd);
        @(negedge clk);
        frame_tick = 1'b0;
        check_state("slots");
        repeat (gap) @(negedge clk);
    endtask

    // monitor: every DUT event pulse must match the next expected event
    always @(negedge clk) begin
        if (rstn && (spawn_pulse || exit_pulse || overflow)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {spawn_pulse, overflow, exit_pulse}, 3'b000);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("event", {spawn_pulse, overflow, exit_pulse, exit_pulse & exit_type},
                    {e.sp, e.ov, e.ex, e.ex & e.et});
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_state", {spawn_pulse, exit_pulse, exit_type, overflow, obj_valid, obj_lane, obj_type, obj_y}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_reset", {spawn_pulse, exit_pulse, overflow, obj_valid}, 64'd0);
        enable = 1'b1;
        repeat (3) @(negedge clk);

        // first spawn on the 60th tick
        for (int t = 0; t < 59; t++) do_tick(5'b11101, 0);
        chk("no_spawn_before_60", obj_valid, 4'b0000);
        do_tick(5'b11101, 0);
        chk("spawn60", {spawn_pulse, obj_valid[0], obj_lane[1:0], obj_type[0], obj_y[9:0]},
            {1'b1, 1'b1, 2'd1, 1'b1, 10'd0});

        // slot0 falls to 478 then exits; the same tick finds all slots full
        for (int t = 0; t < 239; t++) do_tick(5'b11101, 0);
        chk("y478", obj_y[9:0], 10'd478);
        chk("full", obj_valid, 4'b1111);
        do_tick(5'b11101, 0);
        chk("exit240", {obj_valid[0], exit_pulse, exit_type, overflow, spawn_pulse}, 5'b01110);
        chk("ovf_no_change", obj_valid[3:1], 3'b111);

        // rand_data[4:3]=00 suppresses spawning even when eligible
        for (int t = 0; t < 59; t++) do_tick({2'b00, 3'($urandom)}, 0);
        for (int t = 0; t < 10; t++) do_tick({2'b00, 3'($urandom)}, 0);
        chk("no_spawn_00", spawn_pulse, 1'b0);
        do_tick(5'b10110, 0);
        chk("spawn_after_00", spawn_pulse, 1'b1);

        // randomized run
        for (int t = 0; t < 600; t++) do_tick(5'($urandom), $urandom_range(0, 2));

        // freeze: ticks with enable low change nothing
        @(negedge clk);
        enable = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            rand_data  = 5'($urandom);
            @(negedge clk);
            frame_tick = 1'b0;
        end
        check_state("freeze");

        // clear together with a frame tick flushes everything silently
        @(negedge clk);
        enable = 1'b1; clear = 1'b1; frame_tick = 1'b1; rand_data = 5'b11111;
        @(negedge clk);
        clear = 1'b0; frame_tick = 1'b0;
        model_reset();
        chk("clear", {obj_valid, exit_pulse, spawn_pulse, overflow}, 7'd0);
        chk("q_after_clear", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        for (int t = 0; t < 70; t++) do_tick(5'($urandom) | 5'b01000, $urandom_range(0, 1));

        // asynchronous reset between edges
        chk("pre_rst_valid", 64'(obj_valid != '0), 64'd1);
        chk("q_pre_rst", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1 chk("async_rst", {spawn_pulse, exit_pulse, exit_type, overflow, obj_valid, obj_lane, obj_type, obj_y}, 64'd0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        for (int t = 0; t < 65; t++) do_tick(5'($urandom) | 5'b10000, 0);

        repeat (2) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
